// File: rtl/pattern_merge_pkg.sv
// -----------------------------------------------------------------------------
// pattern_merge_pkg
// Shared constants and pure functions for the pattern_merge_pipe block:
//   - lane geometry and input/output bit positions of the pattern cell
//   - cell_fn   : four-function left-side pattern cell, 4-bit in -> {f3,f2,f1,f0}
//   - low_mask  : SIG_W-bit all-ones mask inside the widest signature container
//   - fold_fn   : XOR-fold of a beat into signature-width chunks
//   - misr_step : one MISR update step
// Functions work on fixed maximum-width containers so that they can be shared
// by any parameterisation. Callers must keep N_CH*LANE_W <= MAX_DATA_W and
// SIG_W <= MAX_SIG_W, zero-extend their operands into the containers and take
// the low SIG_W bits of the result.
// -----------------------------------------------------------------------------
package pattern_merge_pkg;

    localparam int LANE_W = 4;

    // Input bit positions inside a lane nibble.
    localparam int IN1_BIT = 0;
    localparam int IN2_BIT = 1;
    localparam int IN3_BIT = 2;
    localparam int IN4_BIT = 3;

    // Output bit position of f0 inside a lane nibble (hit detection).
    localparam int F0_BIT = 0;

    localparam int MAX_DATA_W = 256;
    localparam int MAX_SIG_W  = 64;

    typedef logic [MAX_DATA_W-1:0] wide_data_t;
    typedef logic [MAX_SIG_W-1:0]  wide_sig_t;

    function automatic logic [LANE_W-1:0] cell_fn(input logic [LANE_W-1:0] pat);
        logic in1, in2, in3, in4;
        logic f0, f1, f2, f3;
        in1 = pat[IN1_BIT];
        in2 = pat[IN2_BIT];
        in3 = pat[IN3_BIT];
        in4 = pat[IN4_BIT];
        f0  = in1 & ~in2;
        f1  = in1 & (in3 | in4);
        f2  = in1 & in2;
        f3  = ~in1 & ~in3;
        return {f3, f2, f1, f0};
    endfunction

    // Shifting an all-ones word left by sig_w (which may equal the container
    // width) and inverting yields sig_w ones without any variable bit index.
    function automatic wide_sig_t low_mask(input int sig_w);
        return ~({MAX_SIG_W{1'b1}} << sig_w);
    endfunction

    // Data above the caller's width is zero, so chunks beyond the real beat
    // contribute nothing; sig_w >= 2 bounds the chunk count to MAX_DATA_W/2.
    function automatic wide_sig_t fold_fn(input wide_data_t data, input int sig_w);
        wide_data_t rest;
        wide_sig_t  acc;
        wide_sig_t  mask;
        mask = low_mask(sig_w);
        rest = data;
        acc  = '0;
        for (int c = 0; c < MAX_DATA_W / 2; c++) begin
            acc  = acc ^ (rest[MAX_SIG_W-1:0] & mask);
            rest = rest >> sig_w;
        end
        return acc;
    endfunction

    function automatic wide_sig_t misr_step(input wide_sig_t sig, input wide_sig_t poly,
                                            input wide_sig_t fold, input int sig_w);
        wide_sig_t mask;
        wide_sig_t top;
        mask = low_mask(sig_w);
        top  = sig >> (sig_w - 1);
        return ((sig << 1) ^ (top[0] ? poly : '0) ^ fold) & mask;
    endfunction

endpackage

// File: rtl/pattern_merge_stage.sv
// -----------------------------------------------------------------------------
// pattern_merge_stage
// One elastic register stage of the pattern pipeline. The stage loads
// {valid, data} whenever it is allowed to advance and holds otherwise.
// Ports:
//   clk      in   clock, rising edge
//   srst     in   synchronous active-high reset (clears valid and data)
//   adv_i    in   advance: stage is empty or its successor advances
//   valid_i  in   valid of the beat offered by the previous stage
//   data_i   in   data of the beat offered by the previous stage
//   valid_o  out  registered valid
//   data_o   out  registered data
// -----------------------------------------------------------------------------
module pattern_merge_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         adv_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pattern_merge_pipe.sv
// -----------------------------------------------------------------------------
// pattern_merge_pipe
// N_CH lanes of the four-function pattern cell feeding a DEPTH-stage elastic
// valid/ready pipeline. Output transfers feed a MISR signature and a
// saturating counter of beats with any lane f0 set.
// Ports:
//   blif_clk_net    in   clock, rising edge
//   blif_reset_net  in   synchronous active-high reset
//   in_valid        in   input beat valid
//   in_ready        out  input beat accepted when in_valid & in_ready
//   in_pat          in   lane k at [4k+3:4k]; bit0=IN_1 .. bit3=IN_4
//   sig_en          in   enable signature update on output transfers
//   sig_clr         in   clear signature (wins over update)
//   out_valid       out  output beat valid
//   out_ready       in   downstream accept
//   out_cell        out  lane k = {f3,f2,f1,f0} at [4k+3:4k]
//   sig             out  MISR signature
//   hit_cnt         out  saturating count of transferred beats with any f0=1
// -----------------------------------------------------------------------------
module pattern_merge_pipe
    import pattern_merge_pkg::*;
#(
    parameter int                   N_CH  = 4,
    parameter int                   DEPTH = 2,
    parameter int                   SIG_W = 16,
    parameter logic [MAX_SIG_W-1:0] POLY  = 64'h1021,
    parameter int                   CNT_W = 8
) (
    input  logic                     blif_clk_net,
    input  logic                     blif_reset_net,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CH*LANE_W-1:0]   in_pat,
    input  logic                     sig_en,
    input  logic                     sig_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_CH*LANE_W-1:0]   out_cell,
    output logic [SIG_W-1:0]         sig,
    output logic [CNT_W-1:0]         hit_cnt
);

    localparam int DATA_W = N_CH * LANE_W;

    logic [DATA_W-1:0]             cell_w;
    logic [N_CH-1:0]               f0_w;
    logic [DEPTH:0]                adv;
    logic [DEPTH-1:0]              stg_valid;
    logic [DEPTH-1:0][DATA_W-1:0]  stg_data;
    logic                          xfer;

    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    wide_data_t       data_ext;
    wide_sig_t        sig_ext;
    wide_sig_t        fold_ext;

    genvar gi;

    // Per-lane pattern cell on the input side, and f0 taps on the output side.
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_lane
            assign cell_w[gi*LANE_W +: LANE_W] = cell_fn(in_pat[gi*LANE_W +: LANE_W]);
            assign f0_w[gi] = out_cell[gi*LANE_W + F0_BIT];
        end
    endgenerate

    // Ready ripples back from the output: a stage may load if it is empty or
    // its successor is advancing. This lets a full chain accept and emit in
    // the same cycle when out_ready is high.
    always_comb begin
        adv        = '0;
        adv[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = ~stg_valid[i] | adv[i+1];
        end
    end

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic              v_in;
            logic [DATA_W-1:0] d_in;
            if (gi == 0) begin : g_first
                assign v_in = in_valid;
                assign d_in = cell_w;
            end else begin : g_rest
                assign v_in = stg_valid[gi-1];
                assign d_in = stg_data[gi-1];
            end
            pattern_merge_stage #(
                .W (DATA_W)
            ) u_stage (
                .clk     (blif_clk_net),
                .srst    (blif_reset_net),
                .adv_i   (adv[gi]),
                .valid_i (v_in),
                .data_i  (d_in),
                .valid_o (stg_valid[gi]),
                .data_o  (stg_data[gi])
            );
        end
    endgenerate

    // Stages are cleared during reset and would report ready; hold the
    // upstream off until reset is released.
    assign in_ready  = adv[0] & ~blif_reset_net;
    assign out_valid = stg_valid[DEPTH-1];
    assign out_cell  = stg_data[DEPTH-1];
    assign xfer      = out_valid & out_ready;

    always_comb begin
        data_ext               = '0;
        data_ext[DATA_W-1:0]   = out_cell;
        sig_ext                = '0;
        sig_ext[SIG_W-1:0]     = sig_q;
        fold_ext               = fold_fn(data_ext, SIG_W);

        sig_d = sig_q;
        if (sig_clr) begin
            sig_d = '0;
        end else if (xfer && sig_en) begin
            sig_d = SIG_W'(misr_step(sig_ext, POLY, fold_ext, SIG_W));
        end

        hit_d = hit_q;
        if (xfer && (|f0_w) && !(&hit_q)) begin
            hit_d = hit_q + CNT_W'(1);
        end
    end

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            sig_q <= '0;
            hit_q <= '0;
        end else begin
            sig_q <= sig_d;
            hit_q <= hit_d;
        end
    end

    assign sig     = sig_q;
    assign hit_cnt = hit_q;

endmodule

// File: doc/pattern_merge_pipe.md
Name: pattern_merge_pipe

Overview:
- Parametrised, elastic successor to the flat merged-pattern netlists.
- N_CH lanes each evaluate the fixed four-function left-side pattern cell on a 4-bit input group.
- Results pass through a DEPTH-stage valid/ready pipeline.
- The output side carries a MISR signature and a saturating hit counter, so merged-graph variants can be compared beat-for-beat in simulation and on silicon.

Parameters:
N_CH, 4, number of pattern lanes (>=1)
DEPTH, 2, number of elastic register stages (>=1)
SIG_W, 16, signature register width (>=2)
POLY, 16'h1021, MISR feedback polynomial (low SIG_W bits used)
CNT_W, 8, hit counter width (>=1)

Ports:
blif_clk_net  in  1  single clock, rising edge
blif_reset_net  in  1  reset, synchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_pat  in  4*N_CH  lane k = bits[4k+3:4k]; bit0=IN_1, bit1=IN_2, bit2=IN_3, bit3=IN_4
sig_en  in  1  enable signature update on output transfers
sig_clr  in  1  clear signature to 0
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_cell  out  4*N_CH  lane k = {f3,f2,f1,f0} at bits[4k+3:4k]
sig  out  SIG_W  MISR signature
hit_cnt  out  CNT_W  saturating count of transferred beats with any lane f0=1

Behaviour:
- Clock and reset: one clock, blif_clk_net. Reset blif_reset_net is synchronous and active-high.
- Cell functions, combinational, at the input stage, per lane:
  - f0 = IN_1 & ~IN_2
  - f1 = IN_1 & (IN_3 | IN_4)
  - f2 = IN_1 & IN_2
  - f3 = ~IN_1 & ~IN_3
- Pipeline: DEPTH stages, each holding {valid, 4*N_CH data}.
  - adv[i] = ~v[i] | adv[i+1]; adv[DEPTH] = out_ready.
  - Stage i loads when adv[i]=1 (from stage i-1, or from the cell output for stage 0).
  - Valid propagates with the data; a stage holds its data when adv[i]=0.
- Ports from the pipeline: in_ready = adv[0]; out_valid = v[DEPTH-1]; out_cell = data[DEPTH-1].
- Latency: a beat accepted at edge t appears on out_valid/out_cell after edge t+DEPTH-1, i.e. it is visible in cycle t+DEPTH, provided there are no stalls.
- Throughput: 1 beat/cycle when out_ready=1. Bubbles collapse under stall.
- Full pipeline: when all stages are valid and out_ready=0, in_ready=0 and nothing moves. out_cell stays stable while out_valid&~out_ready.
- Transfer: xfer = out_valid & out_ready.
- Fold: out_cell is XOR-folded into SIG_W bits as chunks of SIG_W, zero-padding the top chunk.
- Signature:
  - On xfer & sig_en: sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ fold.
  - Priority: sig_clr over update. If sig_clr and xfer occur together, sig <= 0 and that beat is excluded from the signature.
- hit_cnt: increments on xfer when any lane f0=1 in out_cell. It saturates at all-ones and is independent of sig_en.
- Reset, including mid-operation: all v<=0, all stage data<=0, sig<=0, hit_cnt<=0.
  - In-flight beats are discarded.
  - in_ready=0 while reset is asserted; in_ready=1 in the first cycle after release.
  - out_valid=0 and out_cell=0 from the first edge with reset asserted.
- Simultaneous accept and emit on a full pipeline is allowed (out_ready=1 frees the chain combinationally).

Decomposition:
- pattern_merge_pkg:
  - cell function (4-bit in -> 4-bit {f3,f2,f1,f0})
  - lane width constant 4
  - fold function
  - MISR step function
  - bit-position constants for IN_1..IN_4
- Sub-module pattern_merge_stage: one elastic register stage (valid, data, adv in/out, sync reset). Instantiated DEPTH times via generate.

Test Plan (N_CH=4, DEPTH=2, SIG_W=16, POLY=16'h1021):
1. Reset, then in_pat=16'h0531, in_valid=1 for one cycle, out_ready=1 -> out_cell=16'h8341, out_valid for exactly one cycle, 2 cycles after accept; hit_cnt=1.
2. sig_en=1; two beats of 16'h0531 from sig=0 -> sig=16'h8341 after the first transfer, 16'h95E2 after the second.
3. Continuous in_valid, out_ready=0 for 4 cycles -> exactly 2 beats accepted, then in_ready=0; out_cell held stable; on out_ready=1, beats emerge in order with no loss or duplication.
4. in_pat=16'h0000 (all lanes f3 only) -> out_cell=16'h8888, hit_cnt unchanged.
5. sig_clr asserted in the same cycle as a transfer with sig_en=1 -> sig=0 next cycle; hit_cnt still counts that beat.
6. Reset asserted with 2 beats in flight -> out_valid=0, sig=0, hit_cnt=0 next cycle; no stale beat emerges after release. Drive 2^CNT_W+5 f0 beats -> hit_cnt saturates at 8'hFF.
